avalon_burst_ram: RTL and testbench
===================================

// Module: avalon_burst_ram
// PURPOSE
//  Parametrised single-port RAM behind an Avalon-MM slave port with byte enables and fixed-increment bursts.
//  Holds frame/pixel data for the edge-detection datapath and is accessed by the Avalon master/DMA.
//  Replaces raw array access: registered read data, readdatavalid, waitrequest back-pressure during read bursts.
// PARAMETERS
//  WORD       32    data width in bits; must be a multiple of 8
//  SIZE       1024  depth in words; any value >= 2
//  BURST_MAX  16    largest legal burstcount; power of 2
// PORTS
//  clk_i            in   1              single clock, rising edge
//  rst_i            in   1              synchronous, active-high reset
//  address_i        in   $clog2(SIZE)   word address, sampled only on accept
//  burstcount_i     in   $clog2(BURST_MAX)+1  beats, sampled only on accept
//  read_i           in   1              read request
//  write_i          in   1              write request / write-burst beat
//  byteenable_i     in   WORD/8         per-byte write mask
//  writedata_i      in   WORD           write data
//  readdata_o       out  WORD           registered read data
//  readdatavalid_o  out  1              readdata_o valid this cycle
//  waitrequest_o    out  1              high = command not accepted
//  parity_err_o     out  1              parity mismatch on returned beat
// BEHAVIOUR
//  Reset: state IDLE; readdata_o=0, readdatavalid_o=0, waitrequest_o=0, parity_err_o=0; array NOT cleared.
//  FSM IDLE / WR_BURST / RD_BURST; waitrequest_o = (state==RD_BURST).
//  Accept = (read_i|write_i) & !waitrequest_o in IDLE. burstcount 0 treated as 1; >BURST_MAX clamped to BURST_MAX.
//  Write accept (cycle t): mem[address_i] lanes with byteenable_i=1 updated at t; others keep old value.
//   N>1: go WR_BURST, beat counter=N-1, address register = address_i+1.
//   WR_BURST: each cycle with write_i=1 writes next address, decrements counter; write_i=0 stalls (no write).
//   Counter reaching 0 -> IDLE. address_i ignored during burst.
//  Read accept (cycle t): mem[address_i] registered; readdata_o valid with readdatavalid_o=1 at t+1.
//   N>1: RD_BURST for cycles t+1..t+N-1, one beat read per cycle; beat k valid at t+1+k with mem[address_i+k].
//   Last beat read at t+N-1 -> IDLE at t+N; back-to-back single reads give readdatavalid_o every cycle.
//  Address increment wraps modulo SIZE (SIZE-1 -> 0); non-power-of-2 SIZE wraps explicitly.
//  read_i & write_i both high in IDLE: write wins, read dropped. read_i in WR_BURST: ignored.
//  Read of address written in cycle t issued at t+1 returns new data (no stale data, no bypass needed).
//  Reset mid-burst: FSM to IDLE, remaining beats discarded, readdatavalid_o=0 next cycle; completed writes persist.
//  readdata_o holds last value when readdatavalid_o=0.
// CONFIGURATION
//  MEM_PARITY_EN defined: array stores one even-parity bit per byte lane (WORD + WORD/8 bits);
//   parity written only for enabled lanes; on each returned beat parity recomputed,
//   parity_err_o=1 in same cycle as readdatavalid_o if any lane mismatches, else 0.
//  MEM_PARITY_EN undefined: no parity storage; parity_err_o tied 0.
// STRUCTURE
//  Package avalon_mem_pkg: FSM state encoding (IDLE/WR_BURST/RD_BURST), burstcount width function,
//   byte-lane parity function, clamp-to-BURST_MAX helper.
//  One sub-module: ram_bank (byte-enabled write, synchronous write, combinational read, WORD/SIZE parameters).
//  Top holds FSM, address/beat counters, output registers, parity check.
// TESTING
//  Reset then write 0xDEADBEEF @5 be=1111, read @5 -> readdatavalid_o at t+1, readdata_o=0xDEADBEEF.
//  Write 0xFFFFFFFF @7, then 0x00000012 be=0001 -> read @7 returns 0xFFFFFF12.
//  Write burst N=4 @SIZE-2 data 1,2,3,4 with one write_i=0 stall -> reads return mem[SIZE-2]=1,[SIZE-1]=2,[0]=3,[1]=4.
//  Read burst N=8 @16 -> waitrequest_o high t+1..t+7, 8 consecutive valid beats, read_i held during waitrequest ignored.
//  rst_i at beat 3 of N=8 read burst -> readdatavalid_o=0 next cycle, waitrequest_o=0, memory contents unchanged.
//  MEM_PARITY_EN: force one stored data bit in ram_bank @9 -> read @9 gives parity_err_o=1 with readdatavalid_o; clean read gives 0.

Source files
------------

// File: rtl/avalon_mem_pkg.sv
// Shared types and helpers for avalon_burst_ram: FSM encoding, burstcount
// sizing, byte-lane parity and burst-length clamping.
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    function automatic int bc_width(input int burst_max);
        return $clog2(burst_max) + 1;
    endfunction

    // Even parity: stored bit makes the 9-bit lane XOR to zero.
    function automatic logic lane_parity(input logic [7:0] lane);
        return ^lane;
    endfunction

    function automatic int clamp_burst(input int n, input int max_beats);
        if (n == 0)
            return 1;
        else if (n > max_beats)
            return max_beats;
        else
            return n;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Byte-lane-writable storage array: synchronous write, combinational read.
// Lane width is WORD/LANES so the parity build can store 9-bit lanes.
module ram_bank #(
    parameter int WORD  = 32,
    parameter int SIZE  = 1024,
    parameter int LANES = 4
) (
    input  logic                    clk_i,
    input  logic                    wr_en,
    input  logic [$clog2(SIZE)-1:0] wr_addr,
    input  logic [LANES-1:0]        wr_lane_en,
    input  logic [WORD-1:0]         wr_word,
    input  logic [$clog2(SIZE)-1:0] rd_addr,
    output logic [WORD-1:0]         rd_word
);

    localparam int LW = WORD / LANES;

    logic [WORD-1:0] mem [SIZE];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane_en[i])
                    mem[wr_addr][i*LW +: LW] <= wr_word[i*LW +: LW];
            end
        end
    end

    assign rd_word = mem[rd_addr];

endmodule

// File: rtl/avalon_burst_ram.sv
// Avalon-MM burst RAM: single-cycle write accept, read data one cycle after accept,
// waitrequest held through read bursts. Optional per-lane parity via MEM_PARITY_EN.
module avalon_burst_ram
    import avalon_mem_pkg::*;
#(
    parameter int WORD      = 32,
    parameter int SIZE      = 1024,
    parameter int BURST_MAX = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [$clog2(SIZE)-1:0]          address_i,
    input  logic [bc_width(BURST_MAX)-1:0]   burstcount_i,
    input  logic                             read_i,
    input  logic                             write_i,
    input  logic [WORD/8-1:0]                byteenable_i,
    input  logic [WORD-1:0]                  writedata_i,
    output logic [WORD-1:0]                  readdata_o,
    output logic                             readdatavalid_o,
    output logic                             waitrequest_o,
    output logic                             parity_err_o
);

    localparam int AW    = $clog2(SIZE);
    localparam int BW    = bc_width(BURST_MAX);
    localparam int LANES = WORD / 8;
`ifdef MEM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int MW = LANES * LANE_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic [BW-1:0]   beats_q;
    logic [BW-1:0]   req_beats;
    logic            wr_en;
    logic            rd_fire;
    logic [AW-1:0]   mem_addr;
    logic [MW-1:0]   wr_word;
    logic [MW-1:0]   rd_word;
    logic [WORD-1:0] rd_data;
    logic            perr_now;

    // Explicit wrap keeps non-power-of-2 depths inside the array.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    always_comb begin
        req_beats = BW'(clamp_burst(32'(burstcount_i), BURST_MAX));
        mem_addr  = (state_q == IDLE) ? address_i : addr_q;
        wr_en     = !rst_i && write_i && (state_q == IDLE || state_q == WR_BURST);
        rd_fire   = !rst_i && ((state_q == IDLE && read_i && !write_i) ||
                               state_q == RD_BURST);
    end

`ifdef MEM_PARITY_EN
    logic [LANES-1:0] lane_err;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef MEM_PARITY_EN
        assign wr_word[i*LANE_W +: LANE_W] = {lane_parity(writedata_i[i*8 +: 8]),
                                              writedata_i[i*8 +: 8]};
        assign lane_err[i] = rd_word[i*LANE_W + 8] != lane_parity(rd_word[i*LANE_W +: 8]);
`else
        assign wr_word[i*LANE_W +: LANE_W] = writedata_i[i*8 +: 8];
`endif
        assign rd_data[i*8 +: 8] = rd_word[i*LANE_W +: 8];
    end

`ifdef MEM_PARITY_EN
    assign perr_now = |lane_err;
`else
    assign perr_now = 1'b0;
`endif

    ram_bank #(
        .WORD  (MW),
        .SIZE  (SIZE),
        .LANES (LANES)
    ) u_bank (
        .clk_i      (clk_i),
        .wr_en      (wr_en),
        .wr_addr    (mem_addr),
        .wr_lane_en (byteenable_i),
        .wr_word    (wr_word),
        .rd_addr    (mem_addr),
        .rd_word    (rd_word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            beats_q         <= '0;
            readdata_o      <= '0;
            readdatavalid_o <= 1'b0;
            parity_err_o    <= 1'b0;
        end else begin
            readdatavalid_o <= rd_fire;
            parity_err_o    <= rd_fire && perr_now;
            if (rd_fire)
                readdata_o <= rd_data;

            case (state_q)
                IDLE: begin
                    if ((write_i || read_i) && req_beats > BW'(1)) begin
                        state_q <= write_i ? WR_BURST : RD_BURST;
                        beats_q <= req_beats - 1'b1;
                        addr_q  <= next_addr(address_i);
                    end
                end
                WR_BURST: begin
                    if (write_i) begin
                        addr_q  <= next_addr(addr_q);
                        beats_q <= beats_q - 1'b1;
                        if (beats_q == BW'(1))
                            state_q <= IDLE;
                    end
                end
                RD_BURST: begin
                    addr_q  <= next_addr(addr_q);
                    beats_q <= beats_q - 1'b1;
                    if (beats_q == BW'(1))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign waitrequest_o = (state_q == RD_BURST);

endmodule

// File: tb/tb_avalon_burst_ram.sv
// Directed bench for avalon_burst_ram: table of single-beat operations plus
// hand-written burst, wrap, clamp, reset-mid-burst and (MEM_PARITY_EN) parity sequences.
module tb_avalon_burst_ram;

    localparam int WORD      = 32;
    localparam int SIZE      = 1024;
    localparam int BURST_MAX = 16;
    localparam int AW        = 10;
    localparam int BW        = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [AW-1:0]   address_i;
    logic [BW-1:0]   burstcount_i;
    logic            read_i;
    logic            write_i;
    logic [3:0]      byteenable_i;
    logic [WORD-1:0] writedata_i;
    logic [WORD-1:0] readdata_o;
    logic            readdatavalid_o;
    logic            waitrequest_o;
    logic            parity_err_o;

    int ntests = 0;
    int nfail  = 0;
    logic [31:0] exp_q[$];

    avalon_burst_ram #(.WORD(WORD), .SIZE(SIZE), .BURST_MAX(BURST_MAX)) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .address_i       (address_i),
        .burstcount_i    (burstcount_i),
        .read_i          (read_i),
        .write_i         (write_i),
        .byteenable_i    (byteenable_i),
        .writedata_i     (writedata_i),
        .readdata_o      (readdata_o),
        .readdatavalid_o (readdatavalid_o),
        .waitrequest_o   (waitrequest_o),
        .parity_err_o    (parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [4:0]  bc;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue a read with exp_q.size() expected beats; optionally keep read_i high
    // (at another address) while waitrequest is asserted.
    task automatic rd_burst(input logic [9:0] addr, input logic [4:0] bc, input bit hold,
                            input string tag);
        int n;
        n = exp_q.size();
        read_i = 1'b1; write_i = 1'b0; address_i = addr; burstcount_i = bc;
        step();
        if (hold) address_i = 10'd600;
        else read_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_vld"}, 32'(readdatavalid_o), 32'd1);
            chk({tag, "_dat"}, readdata_o, exp_q[k]);
            chk({tag, "_wait"}, 32'(waitrequest_o), (k < n - 1) ? 32'd1 : 32'd0);
            chk({tag, "_perr"}, 32'(parity_err_o), 32'd0);
            if (k == n - 1) read_i = 1'b0;
            step();
        end
        chk({tag, "_end_vld"}, 32'(readdatavalid_o), 32'd0);
    endtask

    task automatic wr_burst(input logic [9:0] addr, input int n, input logic [31:0] base);
        write_i = 1'b1; read_i = 1'b0; address_i = addr; burstcount_i = 5'(n);
        byteenable_i = 4'hF; writedata_i = base;
        step();
        for (int k = 1; k < n; k++) begin
            address_i   = ~addr;
            writedata_i = base + 32'(k);
            chk("wrb_wait", 32'(waitrequest_o), 32'd0);
            step();
        end
        write_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 10'd5, 5'd1, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 10'd5, 5'd1, 4'h0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 10'd7, 5'd1, 4'hF, 32'hFFFFFFFF, 32'h0};
        vecs[3]  = '{1'b1, 10'd7, 5'd1, 4'h1, 32'h00000012, 32'h0};
        vecs[4]  = '{1'b0, 10'd7, 5'd1, 4'h0, 32'h0,        32'hFFFFFF12};
        vecs[5]  = '{1'b1, 10'd8, 5'd1, 4'hF, 32'h11223344, 32'h0};
        vecs[6]  = '{1'b1, 10'd8, 5'd1, 4'hA, 32'hAABBCCDD, 32'h0};
        vecs[7]  = '{1'b0, 10'd8, 5'd0, 4'h0, 32'h0,        32'hAA22CC44};
        vecs[8]  = '{1'b0, 10'd5, 5'd1, 4'h0, 32'h0,        32'hDEADBEEF};
        vecs[9]  = '{1'b1, 10'd5, 5'd1, 4'h0, 32'h00000000, 32'h0};
        vecs[10] = '{1'b0, 10'd5, 5'd1, 4'h0, 32'h0,        32'hDEADBEEF};

        rst_i = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
        burstcount_i = 5'd1; byteenable_i = 4'hF; writedata_i = '0;
        repeat (3) step();
        chk("rst_dat",  readdata_o, 32'h0);
        chk("rst_vld",  32'(readdatavalid_o), 32'd0);
        chk("rst_wait", 32'(waitrequest_o), 32'd0);
        chk("rst_perr", 32'(parity_err_o), 32'd0);
        rst_i = 1'b0;
        step();

        foreach (vecs[i]) begin
            write_i = vecs[i].wr; read_i = !vecs[i].wr;
            address_i = vecs[i].addr; burstcount_i = vecs[i].bc;
            byteenable_i = vecs[i].be; writedata_i = vecs[i].wdata;
            step();
            write_i = 1'b0; read_i = 1'b0;
            chk($sformatf("vec%0d_vld", i), 32'(readdatavalid_o), vecs[i].wr ? 32'd0 : 32'd1);
            chk($sformatf("vec%0d_wait", i), 32'(waitrequest_o), 32'd0);
            if (!vecs[i].wr) chk($sformatf("vec%0d_dat", i), readdata_o, vecs[i].exp);
        end
        step();
        chk("hold_vld", 32'(readdatavalid_o), 32'd0);
        chk("hold_dat", readdata_o, 32'hDEADBEEF);

        // Wrapping write burst with one stall beat; address_i must be ignored mid-burst.
        write_i = 1'b1; address_i = 10'd1022; burstcount_i = 5'd4;
        byteenable_i = 4'hF; writedata_i = 32'd1;
        step();
        address_i = 10'd5; writedata_i = 32'd2;
        step();
        write_i = 1'b0; writedata_i = 32'd99;
        step();
        write_i = 1'b1; writedata_i = 32'd3;
        step();
        writedata_i = 32'd4;
        step();
        write_i = 1'b0;
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        rd_burst(10'd1022, 5'd4, 1'b0, "wrap");
        exp_q = '{32'hDEADBEEF};
        rd_burst(10'd5, 5'd1, 1'b0, "untouched");

        wr_burst(10'd16, 16, 32'h100);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h100 + 32'(k));
        rd_burst(10'd16, 5'd8, 1'b1, "rb8");

        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(32'h100 + 32'(k));
        rd_burst(10'd16, 5'd31, 1'b0, "clamp");

        // Reset lands while beat 3 of an 8-beat read is being fetched.
        read_i = 1'b1; address_i = 10'd16; burstcount_i = 5'd8;
        step();
        read_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstm_beat", readdata_o, 32'h100 + 32'(k));
            if (k < 2) step();
        end
        rst_i = 1'b1;
        step();
        chk("rstm_vld",  32'(readdatavalid_o), 32'd0);
        chk("rstm_wait", 32'(waitrequest_o), 32'd0);
        chk("rstm_dat",  readdata_o, 32'h0);
        rst_i = 1'b0;
        step();
        chk("rstm_after_vld", 32'(readdatavalid_o), 32'd0);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h100 + 32'(k));
        rd_burst(10'd16, 5'd8, 1'b0, "rstm_mem");

        write_i = 1'b1; read_i = 1'b1; address_i = 10'd30; burstcount_i = 5'd1;
        byteenable_i = 4'hF; writedata_i = 32'hCAFEF00D;
        step();
        write_i = 1'b0; read_i = 1'b0;
        chk("wr_wins_vld", 32'(readdatavalid_o), 32'd0);
        exp_q = '{32'hCAFEF00D};
        rd_burst(10'd30, 5'd1, 1'b0, "wr_wins");

`ifdef MEM_PARITY_EN
        write_i = 1'b1; address_i = 10'd9; burstcount_i = 5'd1;
        byteenable_i = 4'hF; writedata_i = 32'h0F0F0F0F;
        step();
        write_i = 1'b0; read_i = 1'b1;
        step();
        read_i = 1'b0;
        chk("par_clean_vld",  32'(readdatavalid_o), 32'd1);
        chk("par_clean_perr", 32'(parity_err_o), 32'd0);
        u_dut.u_bank.mem[9][0] = ~u_dut.u_bank.mem[9][0];
        read_i = 1'b1;
        step();
        read_i = 1'b0;
        chk("par_bad_vld",  32'(readdatavalid_o), 32'd1);
        chk("par_bad_perr", 32'(parity_err_o), 32'd1);
        step();
        chk("par_idle_perr", 32'(parity_err_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
